// File: rtl/ipg_msg_tx_inserter.sv
// ipg_msg_tx_inserter
//   Sits between the 64b/66b encoder and the scrambler/gearbox. It replaces
//   all-idle control blocks in inter-packet gaps with message-chunk blocks.
//   Messages come from a small queue. A message cut off by a packet start
//   either resumes at its next chunk or restarts at chunk 0, set by RESUME_EN.
//   The output is always exactly one cycle behind the input.
// Ports
//   clk, rst            clock (one 66b block per cycle), async active-high reset
//   s_hdr, s_data       encoded input block (s_data[7:0] = block type)
//   msg_data/valid/ready  message queue write side (valid&&ready transfers)
//   m_hdr, m_data       output block
//   msg_sent            pulses together with the last chunk of a message
//   msg_active          a message is at the queue head, not yet fully sent
//   preempt_cnt         saturating count of messages cut off by a packet
module ipg_msg_tx_inserter #(
  parameter int          DATA_WIDTH     = 64,
  parameter int          MSG_WIDTH      = 512,
  parameter int          MSG_FIFO_DEPTH = 4,
  parameter logic [7:0]  IPG_BT         = 8'h00,
  parameter int          IDLE_GUARD     = 1,
  parameter int          RESUME_EN      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            s_hdr,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic [MSG_WIDTH-1:0]  msg_data,
  input  logic                  msg_valid,
  output logic                  msg_ready,
  output logic [1:0]            m_hdr,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  msg_sent,
  output logic                  msg_active,
  output logic [15:0]           preempt_cnt
);

  localparam int         NCHUNK    = (MSG_WIDTH + 47) / 48;
  localparam int         PAD_W     = NCHUNK * 48;
  localparam int         AW        = $clog2(MSG_FIFO_DEPTH);
  localparam logic [1:0] SYNC_CTRL = 2'b01;
  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [5:0] LAST_IDX  = 6'(NCHUNK - 1);
  localparam logic [DATA_WIDTH-1:0] IDLE_BLK = DATA_WIDTH'(64'h1e);

  typedef enum logic [1:0] {ST_PKT, ST_GUARD, ST_GAP} gap_st_t;

  gap_st_t st, st_nxt;
  logic [15:0] gcnt, gcnt_nxt;
  logic [5:0]  idx, idx_nxt;
  logic        preempt;

  // message queue
  logic [MSG_WIDTH-1:0] mem [MSG_FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic                 rdy_en;   // keeps ready low until the first edge after reset
  logic                 full, empty, push, pop;

  assign full       = (count == (AW+1)'(MSG_FIFO_DEPTH));
  assign empty      = (count == '0);
  assign msg_ready  = rdy_en && !full;
  assign push       = msg_valid && msg_ready;
  assign msg_active = !empty;

  // input block classification
  logic [7:0] blk_type;
  logic       is_ctrl, is_idle, is_term, is_start, ins, last;

  assign blk_type = s_data[7:0];
  assign is_ctrl  = (s_hdr == SYNC_CTRL);
  assign is_idle  = is_ctrl && (s_data == IDLE_BLK);
  assign is_term  = is_ctrl && (blk_type inside {8'h87, 8'h99, 8'haa, 8'hb4,
                                                 8'hcc, 8'hd2, 8'he1, 8'hff});
  // A bare data block in the gap means we missed the start; treat it as one.
  assign is_start = (is_ctrl && (blk_type == 8'h78 || blk_type == 8'h33)) ||
                    (s_hdr == SYNC_DATA);
  assign ins      = (st == ST_GAP) && is_idle && !empty;
  assign last     = (idx == LAST_IDX);
  assign pop      = ins && last;

  // chunk block built from the queue head, zero-padded past MSG_WIDTH
  logic [PAD_W-1:0]      msg_pad;
  logic [47:0]           payload;
  logic [DATA_WIDTH-1:0] chunk_blk;

  always_comb begin
    msg_pad                = '0;
    msg_pad[MSG_WIDTH-1:0] = mem[rd_ptr];
    payload                = msg_pad[48*int'(idx) +: 48];
    chunk_blk              = {payload, idx, last, (idx == 6'd0), IPG_BT};
  end

  // gap FSM next state
  always_comb begin
    st_nxt   = st;
    gcnt_nxt = gcnt;
    idx_nxt  = idx;
    preempt  = 1'b0;
    case (st)
      ST_PKT: begin
        if (is_term) begin
          if (IDLE_GUARD == 0) begin
            st_nxt = ST_GAP;
          end else begin
            st_nxt   = ST_GUARD;
            gcnt_nxt = 16'(IDLE_GUARD);
          end
        end
      end
      ST_GUARD: begin
        if (is_start) begin
          st_nxt = ST_PKT;
        end else if (is_idle) begin
          gcnt_nxt = gcnt - 16'd1;
          if (gcnt <= 16'd1) st_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (is_start) begin
          st_nxt = ST_PKT;
          if (idx != 6'd0) begin
            preempt = 1'b1;
            if (RESUME_EN == 0) idx_nxt = 6'd0;
          end
        end else if (ins) begin
          idx_nxt = last ? 6'd0 : idx + 6'd1;
        end
      end
      default: st_nxt = ST_GAP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st          <= ST_GAP;
      gcnt        <= '0;
      idx         <= '0;
      preempt_cnt <= '0;
      m_hdr       <= SYNC_CTRL;
      m_data      <= IDLE_BLK;
      msg_sent    <= 1'b0;
      rdy_en      <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      st       <= st_nxt;
      gcnt     <= gcnt_nxt;
      idx      <= idx_nxt;
      rdy_en   <= 1'b1;
      msg_sent <= pop;
      if (ins) begin
        m_hdr  <= SYNC_CTRL;
        m_data <= chunk_blk;
      end else begin
        m_hdr  <= s_hdr;
        m_data <= s_data;
      end
      if (preempt && preempt_cnt != 16'hffff) preempt_cnt <= preempt_cnt + 16'd1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // storage needs no reset; the pointers define what is valid
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= msg_data;
  end

endmodule
